fft_peak_detect: RTL and testbench

FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

---
 rtl/fft_peak_detect.sv | 247 ++++++++++++++++++++++++
 tb/tb_fft_peak_detect.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_detect.sv
// ---------------------------------------------------------------------------
// fft_peak_detect
//
// Reads the positive-frequency half (bins 0 .. N/2-1) of a finished FFT
// result RAM, streams an alpha-max-plus-beta-min magnitude estimate for each
// bin, and reports the largest eligible bin (>= MIN_BIN) once per frame.
//
// A frame starts on a 0->1 edge of done seen while IDLE. The FSM walks
// IDLE -> SWEEP (N/2 reads) -> DRAIN (RD_LAT+1 cycles) -> REPORT (1 cycle).
//
// Parameters
//   width    bit width of each signed real / imaginary component
//   M        log2 of FFT length N
//   RD_LAT   cycles from rd_adr to valid wd (must be >= 1)
//   MIN_BIN  lowest bin eligible for the peak search
//
// Ports
//   clk_slow    in   logic clock, all state on its rising edge
//   reset       in   synchronous, active-low reset
//   done        in   FFT-complete level from the FFT core
//   wd          in   result word {re, im}, both signed
//   rd_adr      out  result RAM read address (0 outside SWEEP)
//   busy        out  high in SWEEP, DRAIN and REPORT
//   mag_valid   out  one-cycle strobe per streamed bin
//   mag_bin     out  bin index of the streamed magnitude
//   mag         out  unsigned magnitude estimate
//   peak_valid  out  one-cycle strobe (REPORT) when the frame peak is final
//   peak_bin    out  bin of the largest magnitude, held until next REPORT
//   peak_mag    out  magnitude at peak_bin, held until next REPORT
//
// Optional feature (macro FFT_PEAK_THRESH_EN)
//   thresh      in   threshold compared against the frame peak
//   peak_hit    out  1 in the REPORT cycle iff peak_mag > thresh
// ---------------------------------------------------------------------------
module fft_peak_detect #(
    parameter int width   = 16,
    parameter int M       = 9,
    parameter int RD_LAT  = 1,
    parameter int MIN_BIN = 1
) (
    input  logic                 clk_slow,
    input  logic                 reset,
    input  logic                 done,
    input  logic [2*width-1:0]   wd,
`ifdef FFT_PEAK_THRESH_EN
    input  logic [width:0]       thresh,
    output logic                 peak_hit,
`endif
    output logic [M-1:0]         rd_adr,
    output logic                 busy,
    output logic                 mag_valid,
    output logic [M-2:0]         mag_bin,
    output logic [width:0]       mag,
    output logic                 peak_valid,
    output logic [M-2:0]         peak_bin,
    output logic [width:0]       peak_mag
);

    localparam int BW = M - 1;                     // bin index width (N/2 bins)
    localparam int CW = $clog2(RD_LAT + 1) + 1;    // drain counter width

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t          state_reg, state_next;

    logic            done_d_reg;
    logic            armed_reg;
    logic            done_rise;
    logic [BW-1:0]   addr_reg;
    logic [CW-1:0]   drain_cnt_reg;
    logic            sweep_last;
    logic            drain_last;

    logic            tail_vld;
    logic [BW-1:0]   tail_bin;

    logic [width:0]  comp_abs [2];                 // [1] = |re|, [0] = |im|
    logic [width:0]  abs_max, abs_min, mag_calc;

    logic            mag_valid_reg;
    logic [BW-1:0]   mag_bin_reg;
    logic [width:0]  mag_reg;
    logic [BW-1:0]   run_bin_reg;
    logic [width:0]  run_mag_reg;
    logic [BW-1:0]   peak_bin_reg;
    logic [width:0]  peak_mag_reg;

    // armed_reg only sets once done has been seen low after reset, so a done
    // level that is already high when reset releases cannot start a frame.
    assign done_rise  = done & ~done_d_reg & armed_reg;
    assign sweep_last = (addr_reg == {BW{1'b1}});
    assign drain_last = (drain_cnt_reg == CW'(RD_LAT));

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk_slow) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (done_rise)  state_next = SWEEP;
            SWEEP:   if (sweep_last) state_next = DRAIN;
            DRAIN:   if (drain_last) state_next = REPORT;
            REPORT:                  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------- control regs
    always_ff @(posedge clk_slow) begin
        if (!reset) begin
            done_d_reg    <= 1'b0;
            armed_reg     <= 1'b0;
            addr_reg      <= '0;
            drain_cnt_reg <= '0;
        end else begin
            done_d_reg <= done;
            if (!done) begin
                armed_reg <= 1'b1;
            end
            // Address wraps to 0 after the last bin, leaving it ready for
            // the next frame.
            addr_reg      <= (state_reg == SWEEP) ? addr_reg + 1'b1 : '0;
            drain_cnt_reg <= (state_reg == DRAIN) ? drain_cnt_reg + 1'b1 : '0;
        end
    end

    assign rd_adr = (state_reg == SWEEP) ? {1'b0, addr_reg} : '0;

    // ------------------------------------- read-latency alignment pipeline
    // Carries the read-valid flag and bin index alongside the RAM access so
    // the tail stage lines up with wd.
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_rd_pipe
        logic          vld_in;
        logic [BW-1:0] bin_in;
        logic          vld_reg;
        logic [BW-1:0] bin_reg;

        if (gi == 0) begin : g_src
            assign vld_in = (state_reg == SWEEP);
            assign bin_in = addr_reg;
        end else begin : g_src
            assign vld_in = g_rd_pipe[gi-1].vld_reg;
            assign bin_in = g_rd_pipe[gi-1].bin_reg;
        end

        always_ff @(posedge clk_slow) begin
            if (!reset) begin
                vld_reg <= 1'b0;
                bin_reg <= '0;
            end else begin
                vld_reg <= vld_in;
                bin_reg <= bin_in;
            end
        end
    end

    assign tail_vld = g_rd_pipe[RD_LAT-1].vld_reg;
    assign tail_bin = g_rd_pipe[RD_LAT-1].bin_reg;

    // ------------------------------------------------------------ magnitude
    // Absolute values are taken one bit wider than the component so that
    // the most negative input maps to +2^(width-1) without wrapping.
    for (genvar gi = 0; gi < 2; gi++) begin : g_abs
        logic [width-1:0] comp;
        assign comp        = wd[gi*width +: width];
        assign comp_abs[gi] = comp[width-1] ? -{comp[width-1], comp}
                                            : {1'b0, comp};
    end

    assign abs_max  = (comp_abs[1] > comp_abs[0]) ? comp_abs[1] : comp_abs[0];
    assign abs_min  = (comp_abs[1] > comp_abs[0]) ? comp_abs[0] : comp_abs[1];
    // max <= 2^(width-1) and min/2 <= 2^(width-2): the sum fits in width+1.
    assign mag_calc = abs_max + (abs_min >> 1);

    // -------------------------------------------- stream and peak tracking
    always_ff @(posedge clk_slow) begin
        if (!reset) begin
            mag_valid_reg <= 1'b0;
            mag_bin_reg   <= '0;
            mag_reg       <= '0;
            run_bin_reg   <= '0;
            run_mag_reg   <= '0;
            peak_bin_reg  <= '0;
            peak_mag_reg  <= '0;
        end else begin
            mag_valid_reg <= tail_vld;
            if (tail_vld) begin
                mag_bin_reg <= tail_bin;
                mag_reg     <= mag_calc;
            end

            // Bins arrive in ascending order, so a strict compare keeps the
            // lower bin on ties. Starting at MIN_BIN/0 makes an all-zero
            // frame report MIN_BIN with magnitude 0.
            if (state_reg == IDLE && done_rise) begin
                run_bin_reg <= BW'(MIN_BIN);
                run_mag_reg <= '0;
            end else if (tail_vld && (tail_bin >= BW'(MIN_BIN))
                         && (mag_calc > run_mag_reg)) begin
                run_bin_reg <= tail_bin;
                run_mag_reg <= mag_calc;
            end

            // Load on REPORT entry so the values are visible together with
            // peak_valid and held until the following REPORT.
            if (state_reg == DRAIN && drain_last) begin
                peak_bin_reg <= run_bin_reg;
                peak_mag_reg <= run_mag_reg;
            end
        end
    end

`ifdef FFT_PEAK_THRESH_EN
    logic peak_hit_reg;

    always_ff @(posedge clk_slow) begin
        if (!reset) begin
            peak_hit_reg <= 1'b0;
        end else begin
            peak_hit_reg <= (state_reg == DRAIN) && drain_last
                            && (run_mag_reg > thresh);
        end
    end

    assign peak_hit = peak_hit_reg;
`endif

    assign busy       = (state_reg != IDLE);
    assign peak_valid = (state_reg == REPORT);
    assign mag_valid  = mag_valid_reg;
    assign mag_bin    = mag_bin_reg;
    assign mag        = mag_reg;
    assign peak_bin   = peak_bin_reg;
    assign peak_mag   = peak_mag_reg;

endmodule

// File: tb/tb_fft_peak_detect.sv
// ---------------------------------------------------------------------------
// tb_fft_peak_detect
//
// Scoreboard bench: each frame's expected magnitude stream, peak and their
// arrival cycles are computed from a RAM image with plain integer
// arithmetic and queued; a monitor pops and compares whenever mag_valid or
// peak_valid is presented. Build with +define+FFT_PEAK_THRESH_EN to also
// exercise thresh / peak_hit.
// ---------------------------------------------------------------------------
module tb_fft_peak_detect;

    localparam int W       = 16;
    localparam int M       = 9;
    localparam int RD_LAT  = 1;
    localparam int MIN_BIN = 1;
    localparam int NB      = 256;

    typedef struct {
        int bin;
        int mag;
        int cyc;
    } mag_exp_t;

    typedef struct {
        int bin;
        int mag;
        int cyc;
        bit hit;
    } peak_exp_t;

    logic             clk_slow = 1'b0;
    logic             reset    = 1'b0;
    logic             done     = 1'b0;
    logic [2*W-1:0]   wd       = '0;
    logic [M-1:0]     rd_adr;
    logic             busy;
    logic             mag_valid;
    logic [M-2:0]     mag_bin;
    logic [W:0]       mag;
    logic             peak_valid;
    logic [M-2:0]     peak_bin;
    logic [W:0]       peak_mag;
`ifdef FFT_PEAK_THRESH_EN
    logic [W:0]       thresh = '0;
    logic             peak_hit;
`endif

    fft_peak_detect #(
        .width   (W),
        .M       (M),
        .RD_LAT  (RD_LAT),
        .MIN_BIN (MIN_BIN)
    ) dut (
        .clk_slow   (clk_slow),
        .reset      (reset),
        .done       (done),
        .wd         (wd),
`ifdef FFT_PEAK_THRESH_EN
        .thresh     (thresh),
        .peak_hit   (peak_hit),
`endif
        .rd_adr     (rd_adr),
        .busy       (busy),
        .mag_valid  (mag_valid),
        .mag_bin    (mag_bin),
        .mag        (mag),
        .peak_valid (peak_valid),
        .peak_bin   (peak_bin),
        .peak_mag   (peak_mag)
    );

    always #5 clk_slow = ~clk_slow;

    // Result RAM model with one cycle of read latency; full N entries so a
    // read from the wrong half shows up as a data mismatch.
    logic [2*W-1:0] ram [0:2*NB-1];
    always @(posedge clk_slow) wd <= ram[rd_adr];

    int cyc = 0;
    always @(posedge clk_slow) cyc <= cyc + 1;

    int        checks   = 0;
    int        failures = 0;
    bit        ignore_mag = 1'b0;
    mag_exp_t  mag_q[$];
    peak_exp_t peak_q[$];
    int        last_bin = 0;
    int        last_mag = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int ref_mag(input logic [31:0] w);
        int re, im, a, b;
        re = int'($signed(w[31:16]));
        im = int'($signed(w[15:0]));
        a  = (re < 0) ? -re : re;
        b  = (im < 0) ? -im : im;
        return ((a > b) ? a : b) + ((a > b) ? b : a) / 2;
    endfunction

    // ---------------------------------------------------------------- monitor
    mag_exp_t  me;
    peak_exp_t pe;
    always @(negedge clk_slow) begin
        if (mag_valid && !ignore_mag) begin
            if (mag_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL mag_unexpected bin=%0d actual=strobe required=none", mag_bin);
            end else begin
                me = mag_q.pop_front();
                check("mag_bin", mag_bin, me.bin);
                check("mag", mag, me.mag);
                check("mag_cycle", cyc, me.cyc);
            end
        end
        if (peak_valid) begin
            if (peak_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL peak_unexpected bin=%0d actual=strobe required=none", peak_bin);
            end else begin
                pe = peak_q.pop_front();
                check("peak_bin", peak_bin, pe.bin);
                check("peak_mag", peak_mag, pe.mag);
                check("peak_cycle", cyc, pe.cyc);
`ifdef FFT_PEAK_THRESH_EN
                check("peak_hit", peak_hit, pe.hit);
`endif
            end
        end
`ifdef FFT_PEAK_THRESH_EN
        else if (peak_hit) begin
            check("peak_hit_outside_report", peak_hit, 0);
        end
`endif
    end

    // ------------------------------------------------------------- stimulus
    task automatic clear_ram;
        for (int i = 0; i < 2*NB; i++) ram[i] = '0;
    endtask

    task automatic rand_ram;
        for (int i = 0; i < 2*NB; i++) begin
            ram[i] = $urandom;
            if ($urandom_range(0, 15) == 0) ram[i] = 32'h8000_8000;
        end
    endtask

    // Queue the expected frame and raise done on this negedge.
    task automatic start_frame;
        int bb, bm, m;
        bit hit;
        @(negedge clk_slow);
        bb = MIN_BIN;
        bm = 0;
        for (int b = 0; b < NB; b++) begin
            m = ref_mag(ram[b]);
            mag_q.push_back('{b, m, cyc + 3 + b});
            if (b >= MIN_BIN && m > bm) begin
                bm = m;
                bb = b;
            end
        end
        hit = 1'b0;
`ifdef FFT_PEAK_THRESH_EN
        hit = (bm > int'(thresh));
`endif
        // done sampled at the next edge: 256 sweep + 2 drain + report
        peak_q.push_back('{bb, bm, cyc + NB + 3, hit});
        last_bin = bb;
        last_mag = bm;
        done = 1'b1;
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        while ((mag_q.size() != 0 || peak_q.size() != 0 || busy) && n < 1000) begin
            @(negedge clk_slow);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=%0d/%0d_pending required=0/0", name,
                     mag_q.size(), peak_q.size());
            mag_q.delete();
            peak_q.delete();
        end else begin
            @(negedge clk_slow);
            check({name, "_peak_bin_held"}, peak_bin, last_bin);
            check({name, "_peak_mag_held"}, peak_mag, last_mag);
        end
    endtask

    task automatic run_frame(input string name);
        start_frame();
        @(negedge clk_slow);
        done = 1'b0;
        wait_frame(name);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_rd_adr"}, rd_adr, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_mag_valid"}, mag_valid, 0);
        check({name, "_mag_bin"}, mag_bin, 0);
        check({name, "_mag"}, mag, 0);
        check({name, "_peak_valid"}, peak_valid, 0);
        check({name, "_peak_bin"}, peak_bin, 0);
        check({name, "_peak_mag"}, peak_mag, 0);
`ifdef FFT_PEAK_THRESH_EN
        check({name, "_peak_hit"}, peak_hit, 0);
`endif
    endtask

    initial begin
        int n;
        bit busy_seen;

        clear_ram();
        reset = 1'b0;
        done  = 1'b0;
        repeat (3) @(negedge clk_slow);
        check_all_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk_slow);

        // Single tone: bin 37 = {1000, -400}
        ram[37] = {16'd1000, 16'hFE70};
`ifdef FFT_PEAK_THRESH_EN
        thresh = 17'd1199;
        run_frame("tone_thr1199");
        thresh = 17'd1200;
`endif
        run_frame("tone");

        // DC exclusion and tie
        clear_ram();
        ram[0] = {16'd30000, 16'd0};
        ram[5] = {16'd500, 16'd500};
        ram[9] = {16'd500, 16'd500};
        run_frame("dc_tie");

        // Most negative components
        clear_ram();
        ram[100] = 32'h8000_8000;
        run_frame("extreme");

        // All zero: peak defaults to MIN_BIN / 0
        clear_ram();
        run_frame("zero");

        // Random frames
        for (int f = 0; f < 3; f++) begin
            rand_ram();
            run_frame("random");
        end

        // done held high for 600 cycles: exactly one frame
        rand_ram();
        start_frame();
        repeat (600) @(negedge clk_slow);
        done = 1'b0;
        wait_frame("held");

        // Fresh edge processes a frame; an edge while busy is ignored
        rand_ram();
        start_frame();
        @(negedge clk_slow);
        done = 1'b0;
        repeat (50) @(negedge clk_slow);
        done = 1'b1;
        @(negedge clk_slow);
        done = 1'b0;
        wait_frame("busy_edge");
        repeat (20) @(negedge clk_slow);
        ram[37] = {16'd1000, 16'hFE70};
        run_frame("after_busy_edge");

        // Reset in the middle of a sweep
        rand_ram();
        ignore_mag = 1'b1;
        @(negedge clk_slow);
        done = 1'b1;
        n = 0;
        while (rd_adr != 9'd120 && n < 500) begin
            @(negedge clk_slow);
            n++;
        end
        check("sweep_reached_120", rd_adr, 120);
        reset = 1'b0;
        @(negedge clk_slow);
        check_all_zero("midreset");
        reset = 1'b1;
        ignore_mag = 1'b0;
        // done is still high at release: no frame may start
        busy_seen = 1'b0;
        repeat (300) begin
            @(negedge clk_slow);
            busy_seen |= busy;
        end
        check("done_high_at_release_busy", busy_seen, 0);
        check("midreset_peak_bin_kept", peak_bin, 0);
        check("midreset_peak_mag_kept", peak_mag, 0);
        done = 1'b0;
        @(negedge clk_slow);
        run_frame("after_reset");

        repeat (5) @(negedge clk_slow);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
